// File: rtl/shift_word_feeder_if.sv
// Upstream word handshake for shift_word_feeder: one parallel word plus its
// shift direction, transferred on in_valid && in_ready.
interface shift_word_feeder_if #(
   parameter int WIDTH = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_dir;

   modport master (
      output in_valid,
      output in_data,
      output in_dir,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_dir,
      output in_ready
   );
endinterface

// File: rtl/shift_word_feeder.sv
// Feeds the serial-in bidirectional shift register: buffers parallel words
// in a small FIFO and serialises each one so that after WIDTH enabled cycles
// the downstream register holds the word exactly.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no word in flight; pops the FIFO head when one is available
// S_SHIFT | driving sr_en=1, one bit per cycle, bit_cnt counts down to 0
// S_GAP   | sr_en=0 spacer after a word, gap_cnt counts down to 0
module shift_word_feeder #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   shift_word_feeder_if.slave     up,
   output logic                   sr_d,
   output logic                   sr_en,
   output logic                   sr_dir,
   output logic                   word_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = 4;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH:0]   mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH:0]   head;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             last_bit;
   logic [WIDTH-1:0] sbuf;
   logic             dir_q;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             done_pend;

   // No pass-through: a full FIFO refuses even when a pop happens this cycle.
   assign up.in_ready = rstn && (fifo_count < FULL_CNT);
   assign push        = up.in_valid && up.in_ready;
   assign fifo_empty  = (fifo_count == '0);
   assign head        = mem[rd_ptr];
   assign last_bit    = (state == S_SHIFT) && (bit_cnt == '0);
   // With GAP=0 the last bit of one word and the load of the next share a cycle.
   assign pop         = !fifo_empty && ((state == S_IDLE) || (last_bit && (GAP == 0)));
   assign busy        = (state != S_IDLE);

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage, {dir, data} per entry
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {up.in_dir, up.in_data};
   end

   // Sequencer: load, serialise, space out words; all pin outputs registered
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_IDLE;
         sbuf      <= '0;
         dir_q     <= 1'b0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         done_pend <= 1'b0;
         sr_d      <= 1'b0;
         sr_en     <= 1'b0;
         sr_dir    <= 1'b0;
         word_done <= 1'b0;
      end else begin
         word_done <= done_pend;
         done_pend <= 1'b0;
         sr_en     <= 1'b0;
         sr_d      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  sbuf    <= head[WIDTH-1:0];
                  dir_q   <= head[WIDTH];
                  bit_cnt <= BIT_LOAD;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               sr_en  <= 1'b1;
               sr_dir <= dir_q;
               // dir=1 register fills from its MSB, so LSB goes first
               if (dir_q) begin
                  sr_d <= sbuf[0];
                  sbuf <= sbuf >> 1;
               end else begin
                  sr_d <= sbuf[WIDTH-1];
                  sbuf <= sbuf << 1;
               end
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
               end else begin
                  done_pend <= 1'b1;
                  if (GAP > 0) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= S_GAP;
                  end else if (!fifo_empty) begin
                     sbuf    <= head[WIDTH-1:0];
                     dir_q   <= head[WIDTH];
                     bit_cnt <= BIT_LOAD;
                  end else begin
                     state   <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) state <= S_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_word_feeder.sv
// Bench for shift_word_feeder: two instances (GAP=0 and GAP=1) run side by
// side against a cycle-schedule reference model and a model of the
// downstream shift register.
module tb_shift_word_feeder;
   localparam int W    = 4;
   localparam int D    = 4;
   localparam int CW   = $clog2(D) + 1;
   localparam int RING = 64;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   shift_word_feeder_if #(.WIDTH(W)) bus0 ();
   shift_word_feeder_if #(.WIDTH(W)) bus1 ();

   logic          sr_d0, sr_en0, sr_dir0, done0, busy0;
   logic          sr_d1, sr_en1, sr_dir1, done1, busy1;
   logic [CW-1:0] cnt0, cnt1;

   shift_word_feeder #(.WIDTH(W), .DEPTH(D), .GAP(0)) u_dut_g0 (
      .clk(clk), .rstn(rstn), .up(bus0),
      .sr_d(sr_d0), .sr_en(sr_en0), .sr_dir(sr_dir0),
      .word_done(done0), .busy(busy0), .fifo_count(cnt0)
   );

   shift_word_feeder #(.WIDTH(W), .DEPTH(D), .GAP(1)) u_dut_g1 (
      .clk(clk), .rstn(rstn), .up(bus1),
      .sr_d(sr_d1), .sr_en(sr_en1), .sr_dir(sr_dir1),
      .word_done(done1), .busy(busy1), .fifo_count(cnt1)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int gapv [2]    = '{0, 1};

   // stimulus per instance
   logic         drv_v   [2];
   logic [W-1:0] drv_d   [2];
   logic         drv_dir [2];
   logic         pushk   [2];

   // reference model: FIFO contents and the output schedule by cycle
   logic [W:0]   fq   [2][$];
   int           fq_t [2][$];
   logic         s_en   [2][RING];
   logic         s_d    [2][RING];
   logic         s_dir  [2][RING];
   logic         s_done [2][RING];
   logic [W-1:0] s_word [2][RING];
   int           free_at    [2];
   int           busy_until [2];
   logic         exp_dir    [2];
   logic [W-1:0] dreg [2];
   logic         pd [2], pen [2], pdir [2];
   int           ndone [2];

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s gap%0d cyc %0d: observed %0h expected %0h", tag, gapv[k], cyc, obs, exp);
      end
   endtask

   task automatic clear_model(input int k);
      fq[k].delete();
      fq_t[k].delete();
      for (int i = 0; i < RING; i++) begin
         s_en[k][i] = 1'b0; s_d[k][i] = 1'b0; s_dir[k][i] = 1'b0;
         s_done[k][i] = 1'b0; s_word[k][i] = '0;
      end
      free_at[k]    = 0;
      busy_until[k] = -1;
      exp_dir[k]    = 1'b0;
   endtask

   task automatic model_step(input int k, input logic rs);
      int           t;
      int           s;
      int           slot;
      logic [W:0]   hw;
      logic         o_d, o_en, o_dir, o_done, o_busy;
      logic [CW-1:0] o_cnt;
      t = cyc;
      s = t % RING;
      if (k == 0) begin
         o_d = sr_d0; o_en = sr_en0; o_dir = sr_dir0; o_done = done0; o_busy = busy0; o_cnt = cnt0;
      end else begin
         o_d = sr_d1; o_en = sr_en1; o_dir = sr_dir1; o_done = done1; o_busy = busy1; o_cnt = cnt1;
      end
      // downstream register took last cycle's pins at this edge
      if (pen[k]) dreg[k] = pdir[k] ? {pd[k], dreg[k][W-1:1]} : {dreg[k][W-2:0], pd[k]};
      if (!rs) begin
         clear_model(k);
      end else begin
         if (pushk[k]) begin
            fq[k].push_back({drv_dir[k], drv_d[k]});
            fq_t[k].push_back(t);
         end
         if (fq[k].size() > 0 && fq_t[k][0] < t && t >= free_at[k]) begin
            hw = fq[k].pop_front();
            void'(fq_t[k].pop_front());
            for (int i = 0; i < W; i++) begin
               slot = (t + 1 + i) % RING;
               s_en[k][slot]  = 1'b1;
               s_dir[k][slot] = hw[W];
               s_d[k][slot]   = hw[W] ? hw[i] : hw[W-1-i];
            end
            slot = (t + W + 1) % RING;
            s_done[k][slot] = 1'b1;
            s_word[k][slot] = hw[W-1:0];
            free_at[k]    = t + W + ((gapv[k] > 0) ? gapv[k] + 1 : 0);
            busy_until[k] = t + W + gapv[k] - 1;
         end
      end
      if (s_en[k][s]) exp_dir[k] = s_dir[k][s];
      chk("sr_en",      k, o_en,   s_en[k][s]);
      chk("sr_d",       k, o_d,    s_d[k][s]);
      chk("sr_dir",     k, o_dir,  exp_dir[k]);
      chk("word_done",  k, o_done, s_done[k][s]);
      chk("busy",       k, o_busy, (t <= busy_until[k]));
      chk("fifo_count", k, o_cnt,  fq[k].size());
      if (s_done[k][s]) chk("landed_word", k, dreg[k], s_word[k][s]);
      if (o_done) ndone[k]++;
      s_en[k][s] = 1'b0; s_d[k][s] = 1'b0; s_dir[k][s] = 1'b0; s_done[k][s] = 1'b0;
      pd[k] = o_d; pen[k] = o_en; pdir[k] = o_dir;
   endtask

   task automatic tick(input logic rs);
      logic exp_rdy;
      bus0.in_valid = drv_v[0]; bus0.in_data = drv_d[0]; bus0.in_dir = drv_dir[0];
      bus1.in_valid = drv_v[1]; bus1.in_data = drv_d[1]; bus1.in_dir = drv_dir[1];
      rstn = rs;
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_rdy = rs && (fq[k].size() < D);
         chk("in_ready", k, (k == 0) ? bus0.in_ready : bus1.in_ready, exp_rdy);
         pushk[k] = drv_v[k] && exp_rdy;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k, rs);
   endtask

   task automatic set_all(input logic v, input logic [W-1:0] d, input logic dr);
      for (int k = 0; k < 2; k++) begin
         drv_v[k] = v; drv_d[k] = d; drv_dir[k] = dr;
      end
   endtask

   task automatic run(input logic v, input logic [W-1:0] d, input logic dr, input logic rs, input int n);
      set_all(v, d, dr);
      for (int i = 0; i < n; i++) tick(rs);
   endtask

   initial begin
      int nxt [2];
      int base [2];
      int guard;
      for (int k = 0; k < 2; k++) begin
         clear_model(k);
         dreg[k] = '0; pd[k] = 1'b0; pen[k] = 1'b0; pdir[k] = 1'b0; ndone[k] = 0;
      end

      // reset held with valid asserted: nothing accepted
      run(1'b1, 4'hF, 1'b0, 1'b0, 3);
      run(1'b0, 4'h0, 1'b0, 1'b1, 2);

      // single word, MSB first then LSB first
      run(1'b1, 4'b1011, 1'b0, 1'b1, 1);
      run(1'b0, 4'h0,    1'b0, 1'b1, 10);
      run(1'b1, 4'b1011, 1'b1, 1'b1, 1);
      run(1'b0, 4'h0,    1'b0, 1'b1, 10);

      // valid held high, words 1..8, pushed only when accepted
      for (int k = 0; k < 2; k++) begin nxt[k] = 1; base[k] = ndone[k]; end
      guard = 0;
      while ((nxt[0] <= 8 || nxt[1] <= 8) && guard < 200) begin
         for (int k = 0; k < 2; k++) begin
            drv_v[k]   = (nxt[k] <= 8);
            drv_d[k]   = nxt[k][W-1:0];
            drv_dir[k] = nxt[k][0];
         end
         tick(1'b1);
         for (int k = 0; k < 2; k++) if (pushk[k]) nxt[k]++;
         guard++;
      end
      run(1'b0, 4'h0, 1'b0, 1'b1, 50);
      for (int k = 0; k < 2; k++) begin
         chk("stream_accepted", k, nxt[k], 9);
         chk("stream_done_pulses", k, ndone[k] - base[k], 8);
      end

      // back-to-back words with a direction change
      run(1'b1, 4'hA, 1'b0, 1'b1, 1);
      run(1'b1, 4'h5, 1'b1, 1'b1, 1);
      run(1'b0, 4'h0, 1'b0, 1'b1, 14);

      // reset after two bits of a word with two more queued
      for (int k = 0; k < 2; k++) base[k] = ndone[k];
      run(1'b1, 4'h3, 1'b0, 1'b1, 1);
      run(1'b1, 4'hC, 1'b1, 1'b1, 1);
      run(1'b1, 4'h9, 1'b0, 1'b1, 1);
      run(1'b0, 4'h0, 1'b0, 1'b1, 1);
      run(1'b0, 4'h0, 1'b0, 1'b0, 1);
      run(1'b0, 4'h0, 1'b0, 1'b1, 8);
      for (int k = 0; k < 2; k++) chk("abandoned_no_done", k, ndone[k] - base[k], 0);
      run(1'b1, 4'h6, 1'b0, 1'b1, 1);
      run(1'b0, 4'h0, 1'b0, 1'b1, 10);
      for (int k = 0; k < 2; k++) chk("after_reset_done", k, ndone[k] - base[k], 1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         set_all(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         tick(($urandom_range(0, 99) != 0));
      end
      run(1'b0, 4'h0, 1'b0, 1'b1, 40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
